// File: rtl/adder_block.sv
// adder_block: registered WIDTH-bit ripple-carry adder with carry-in/out,
// signed-overflow and zero flags; optional input stage via ADDER_BLOCK_INREG_EN.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      a/b/cin valid this cycle
//   a, b       in   WIDTH  unsigned operands
//   cin        in   1      carry-in
//   out_valid  out  1      new result present this cycle
//   sum        out  WIDTH  registered (a+b+cin)[WIDTH-1:0]
//   cout       out  1      registered carry out of MSB
//   ovf        out  1      registered signed overflow
//   zero       out  1      registered sum==0 flag
//
// Macro ADDER_BLOCK_INREG_EN: adds a registered input stage (latency 2).
module adder_block #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    logic             w_vld;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_cin;

`ifdef ADDER_BLOCK_INREG_EN
    logic             r_vld_q;
    logic [WIDTH-1:0] r_a_q;
    logic [WIDTH-1:0] r_b_q;
    logic             r_cin_q;

    // Operands are only captured when valid so X/Z on idle
    // inputs never reaches the adder core.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_q <= 1'b0;
            r_a_q   <= '0;
            r_b_q   <= '0;
            r_cin_q <= 1'b0;
        end else begin
            r_vld_q <= in_valid;
            if (in_valid) begin
                r_a_q   <= a;
                r_b_q   <= b;
                r_cin_q <= cin;
            end
        end
    end

    assign w_vld = r_vld_q;
    assign w_a   = r_a_q;
    assign w_b   = r_b_q;
    assign w_cin = r_cin_q;
`else
    assign w_vld = in_valid;
    assign w_a   = a;
    assign w_b   = b;
    assign w_cin = cin;
`endif

    // Ripple chain of full-adder cells; w_c[i] is carry into bit i.
    logic [WIDTH-1:0] w_s;
    logic [WIDTH:0]   w_c;

    always_comb begin
        w_s    = '0;
        w_c    = '0;
        w_c[0] = w_cin;
        for (int i = 0; i < WIDTH; i++) begin
            w_s[i]   = w_a[i] ^ w_b[i] ^ w_c[i];
            w_c[i+1] = (w_a[i] & w_b[i])
                     | (w_c[i] & (w_a[i] ^ w_b[i]));
        end
    end

    logic w_ovf;
    logic w_zero;

    assign w_ovf  = w_c[WIDTH] ^ w_c[WIDTH-1];
    assign w_zero = (w_s == '0);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    // Result fields hold across idle cycles; only out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b1;
        end else begin
            r_out_valid <= w_vld;
            if (w_vld) begin
                r_sum  <= w_s;
                r_cout <= w_c[WIDTH];
                r_ovf  <= w_ovf;
                r_zero <= w_zero;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_adder_block.sv
// tb_adder_block: scoreboard bench for adder_block (WIDTH=4).
// Expected results are queued at the accepting edge and popped on out_valid.
module tb_adder_block;

    localparam int W = 4;
`ifdef ADDER_BLOCK_INREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        logic         z;
    } res_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    adder_block #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic         c);
        res_t r;
        logic [W:0] t;
        t    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        r.s  = t[W-1:0];
        r.co = t[W];
        r.ov = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
        r.z  = (r.s == '0);
        return r;
    endfunction

    res_t       sb[$];
    res_t       held;
    logic [1:0] vhist;
    bit         mon_en = 1'b0;

    // Reference pipeline: tracks which edges accepted data.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            vhist = '0;
            held  = '{s: '0, co: 1'b0, ov: 1'b0, z: 1'b1};
        end else begin
            if (in_valid)
                sb.push_back(model(a, b, cin));
            vhist = {vhist[0], in_valid};
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", {31'b0, out_valid},
                  {31'b0, vhist[L-1]});
            if (vhist[L-1]) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    held = sb.pop_front();
                end
            end
            check("sum",  {28'b0, sum},  {28'b0, held.s});
            check("cout", {31'b0, cout}, {31'b0, held.co});
            check("ovf",  {31'b0, ovf},  {31'b0, held.ov});
            check("zero", {31'b0, zero}, {31'b0, held.z});
        end
    end

    task automatic step(input logic         v,
                        input logic [W-1:0] x,
                        input logic [W-1:0] y,
                        input logic         c);
        in_valid = v;
        a        = x;
        b        = y;
        cin      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        a        = 'x;
        b        = 'x;
        cin      = 1'bx;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        #1;
        check("rst_sum",  {28'b0, sum},  32'd0);
        check("rst_zero", {31'b0, zero}, 32'd1);
        check("rst_ov",   {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        step(1'b1, 4'd0, 4'd2, 1'b0);
        step(1'b1, 4'd3, 4'd2, 1'b0);
        idle();
        idle();
        idle();
        step(1'b1, 4'd15, 4'd0, 1'b1);
        step(1'b1, 4'd7, 4'd1, 1'b0);
        idle();
        idle();

        for (int i = 1; i <= 15; i++)
            step(1'b1, W'(i), 4'd1, 1'b0);
        idle();
        idle();

        for (int i = 0; i < 6; i++)
            step(1'b1, W'(i + 3), 4'd9, 1'b1);
        rst = 1'b1;
        step(1'b1, 4'd5, 4'd5, 1'b0);
        rst = 1'b0;
        step(1'b1, 4'd6, 4'd6, 1'b1);
        idle();
        idle();

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0)
                step(1'b1, W'($urandom), W'($urandom),
                     1'($urandom));
            else
                idle();
        end
        idle();
        idle();
        idle();

        @(negedge clk);
        #1;
        check("sb_empty", sb.size(), 32'd0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d",
                 n_chk, n_fail);
        $finish;
    end

endmodule
